char_pixel_sequencer: RTL and testbench

//  Sequences the 8x16 glyph ROM (char_generator) for text-mode VGA output.

---
 rtl/char_pixel_sequencer_if.sv | 31 +++
 rtl/char_pixel_sequencer.sv | 134 +++++++++++++
 tb/tb_char_pixel_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/char_pixel_sequencer_if.sv
// char_pixel_sequencer_if: pixel-side bus of the text-mode sequencer.
// The master side is the sync generator / glyph ROM / cursor logic. The slave side
// is the sequencer, which returns the ROM row address and the delayed video signals.
interface char_pixel_sequencer_if;
    logic        pix_en;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [3:0]  rom_row;
    logic [7:0]  rom_data;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;

    modport master (
        output pix_en, video_on, hsync_in, vsync_in, pixel_x, pixel_y,
               cursor_en, cursor_col, cursor_row, rom_data,
        input  rom_row, rgb, hsync_out, vsync_out
    );

    modport slave (
        input  pix_en, video_on, hsync_in, vsync_in, pixel_x, pixel_y,
               cursor_en, cursor_col, cursor_row, rom_data,
        output rom_row, rgb, hsync_out, vsync_out
    );
endinterface

// File: rtl/char_pixel_sequencer.sv
// char_pixel_sequencer: tiles an 8x16 glyph over a COLS x ROWS character window.
// Stage 1 registers the ROM row address and per-pixel flags. Stage 2 serializes
// the returned glyph row and produces the colour. The syncs follow the same
// two-strobe delay so that they stay aligned with rgb.
module char_pixel_sequencer #(
    parameter int          X0           = 0,
    parameter int          Y0           = 0,
    parameter int          COLS         = 80,
    parameter int          ROWS         = 30,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] FG           = 12'hFFF,
    parameter logic [11:0] BG           = 12'h000
) (
    input logic                   clk,
    input logic                   reset,
    char_pixel_sequencer_if.slave bus
);
    // The window bounds are held in 11 bits: X0+8*COLS can reach 1024.
    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + 8 * COLS);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + 16 * ROWS);
    localparam int          CW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

    logic          win;
    logic [9:0]    dx;
    logic [9:0]    dy;
    logic [2:0]    col;
    logic [6:0]    cell_c;
    logic [5:0]    cell_r;
    logic          cur_hit;

    logic [CW-1:0] frame_cnt;
    logic          blink_phase;
    logic          vs_prev;
    logic          vs_fall;

    logic [2:0]    s1_col;
    logic          s1_win;
    logic          s1_cur;
    logic          s1_hs;
    logic          s1_vs;

    logic [7:0]    shreg;
    logic [7:0]    shreg_next;
    logic          pix_bit;

    // Stage 0: window test and cell coordinates. Underflow of dx/dy is harmless because win gates it.
    always_comb begin
        win = bus.video_on
              && ({1'b0, bus.pixel_x} >= X_LO) && ({1'b0, bus.pixel_x} < X_HI)
              && ({1'b0, bus.pixel_y} >= Y_LO) && ({1'b0, bus.pixel_y} < Y_HI);
        dx      = bus.pixel_x - X_LO[9:0];
        dy      = bus.pixel_y - Y_LO[9:0];
        col     = dx[2:0];
        cell_c  = dx[9:3];
        cell_r  = dy[9:4];
        cur_hit = bus.cursor_en && blink_phase
                  && (cell_c == bus.cursor_col)
                  && (cell_r == {1'b0, bus.cursor_row});
    end

    assign vs_fall = vs_prev & ~bus.vsync_in;

    // Blink timebase: count vsync falls and toggle the cursor phase every BLINK_FRAMES frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            vs_prev     <= 1'b0;
        end else if (bus.pix_en) begin
            vs_prev <= bus.vsync_in;
            if (vs_fall) begin
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Stage 1: present the glyph row to the ROM and carry the pixel flags alongside it.
    // The sync registers reset to the idle (high) level so that no sync pulse is emitted after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rom_row <= '0;
            s1_col      <= '0;
            s1_win      <= 1'b0;
            s1_cur      <= 1'b0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
        end else if (bus.pix_en) begin
            bus.rom_row <= dy[3:0];
            s1_col      <= col;
            s1_win      <= win;
            s1_cur      <= cur_hit;
            s1_hs       <= bus.hsync_in;
            s1_vs       <= bus.vsync_in;
        end
    end

    // Serializer: load the ROM row at the first column of a cell, shift it out afterwards, clear outside the window.
    always_comb begin
        shreg_next = '0;
        pix_bit    = 1'b0;
        if (s1_win) begin
            if (s1_col == 3'd0) begin
                pix_bit    = bus.rom_data[7];
                shreg_next = {bus.rom_data[6:0], 1'b0};
            end else begin
                pix_bit    = shreg[7];
                shreg_next = {shreg[6:0], 1'b0};
            end
        end
    end

    // Stage 2: register the shifter, the final colour and the delayed syncs.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg         <= '0;
            bus.rgb       <= 12'h000;
            bus.hsync_out <= 1'b1;
            bus.vsync_out <= 1'b1;
        end else if (bus.pix_en) begin
            shreg         <= shreg_next;
            bus.rgb       <= s1_win ? ((pix_bit ^ s1_cur) ? FG : BG) : 12'h000;
            bus.hsync_out <= s1_hs;
            bus.vsync_out <= s1_vs;
        end
    end
endmodule

// File: tb/tb_char_pixel_sequencer.sv
// tb_char_pixel_sequencer: drives a small raster through the sequencer and compares
// every output against a behavioural model of the text-mode pixel pipeline.
module tb_char_pixel_sequencer;
    localparam int          X0      = 8;
    localparam int          Y0      = 16;
    localparam int          COLS    = 4;
    localparam int          ROWS    = 2;
    localparam int          BLINK   = 2;
    localparam logic [11:0] FG      = 12'hABC;
    localparam logic [11:0] BG      = 12'h123;
    localparam int          H_TOTAL = 48;
    localparam int          V_TOTAL = 56;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] glyph [16];

    int checks = 0;
    int errors = 0;

    char_pixel_sequencer_if bus();

    char_pixel_sequencer #(
        .X0(X0), .Y0(Y0), .COLS(COLS), .ROWS(ROWS),
        .BLINK_FRAMES(BLINK), .FG(FG), .BG(BG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    // The glyph ROM answers combinationally to the registered row address.
    assign bus.rom_data = glyph[bus.rom_row];

    // 50 MHz system clock.
    always #10 clk = ~clk;

    // Model state: expectations become visible one strobe after they are computed.
    bit          m_ready   = 1'b0;
    bit          m_sync_ok = 1'b0;
    bit          m_loaded;
    bit          m_prev_vs;
    int          m_falls;
    int          m_strobes;
    logic [11:0] m_pend_rgb, m_exp_rgb;
    logic        m_pend_hs, m_exp_hs, m_pend_vs, m_exp_vs;
    logic [3:0]  m_exp_row;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit vid, input bit hs, input bit vs,
                                 input int x, input int y);
        bus.pix_en   = en;
        bus.video_on = vid;
        bus.hsync_in = hs;
        bus.vsync_in = vs;
        bus.pixel_x  = 10'(x);
        bus.pixel_y  = 10'(y);
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: colour of a pixel from glyph, window, cursor and frame count.
    always @(posedge clk) begin : model
        int x, y, dx, dy, col;
        bit inwin, bitv, cur, phase;
        if (reset) begin
            m_ready    = 1'b1;
            m_sync_ok  = 1'b1;
            m_loaded   = 1'b0;
            m_prev_vs  = 1'b0;
            m_falls    = 0;
            m_strobes  = 0;
            m_pend_rgb = 12'h000; m_exp_rgb = 12'h000;
            m_pend_hs  = 1'b1;    m_exp_hs  = 1'b1;
            m_pend_vs  = 1'b1;    m_exp_vs  = 1'b1;
            m_exp_row  = 4'd0;
        end else if (bus.pix_en) begin
            x     = int'(bus.pixel_x);
            y     = int'(bus.pixel_y);
            dx    = x - X0;
            dy    = y - Y0;
            inwin = bus.video_on && x >= X0 && x < X0 + 8 * COLS && y >= Y0 && y < Y0 + 16 * ROWS;
            phase = ((m_falls / BLINK) % 2) == 1;
            m_exp_rgb = m_pend_rgb;
            m_exp_hs  = m_pend_hs;
            m_exp_vs  = m_pend_vs;
            m_exp_row = 4'(dy & 15);
            if (inwin) begin
                col = dx % 8;
                if (col == 0) m_loaded = 1'b1;
                bitv = m_loaded ? glyph[dy % 16][7 - col] : 1'b0;
                cur  = bus.cursor_en && phase
                       && (dx / 8 == int'(bus.cursor_col)) && (dy / 16 == int'(bus.cursor_row));
                m_pend_rgb = (bitv ^ cur) ? FG : BG;
            end else begin
                m_loaded   = 1'b0;
                m_pend_rgb = 12'h000;
            end
            m_pend_hs = bus.hsync_in;
            m_pend_vs = bus.vsync_in;
            if (m_prev_vs && !bus.vsync_in) m_falls++;
            m_prev_vs = bus.vsync_in;
            if (m_strobes < 2) m_strobes++;
            m_sync_ok = (m_strobes >= 2);
        end
    end

    // Compare every output against the model on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (m_ready) begin
            checkOutput("rgb", int'(bus.rgb), int'(m_exp_rgb));
            checkOutput("rom_row", int'(bus.rom_row), int'(m_exp_row));
            if (m_sync_ok) begin
                checkOutput("hsync_out", int'(bus.hsync_out), int'(m_exp_hs));
                checkOutput("vsync_out", int'(bus.vsync_out), int'(m_exp_vs));
            end
        end
    end

    task automatic runFrames(input int n);
        bit line_vid, vid, hs, vs;
        int gap;
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < 16; i++) glyph[i] = 8'($urandom);
            for (int y = 0; y < V_TOTAL; y++) begin
                line_vid = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 3) == 0) begin
                    bus.cursor_en  = ($urandom_range(0, 3) != 0);
                    bus.cursor_col = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                                                : 7'($urandom_range(0, 5));
                    bus.cursor_row = 5'($urandom_range(0, 2));
                end
                for (int x = 0; x < H_TOTAL; x++) begin
                    vid = line_vid && x < 44 && y < 52;
                    hs  = !(x >= 44 && x < 46);
                    vs  = !(y >= 53 && y < 55);
                    gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                    for (int g = 0; g < gap; g++) applyStimulus(1'b0, vid, hs, vs, x, y);
                    applyStimulus(1'b1, vid, hs, vs, x, y);
                end
            end
        end
    endtask

    // Directed checks that pin the model, then randomized frames, then a mid-line reset.
    initial begin
        for (int i = 0; i < 16; i++) glyph[i] = 8'h00;
        glyph[8]       = 8'hFE;
        bus.cursor_en  = 1'b0;
        bus.cursor_col = 7'd0;
        bus.cursor_row = 5'd0;

        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        checkOutput("reset_rgb", int'(bus.rgb), 0);
        checkOutput("reset_hs", int'(bus.hsync_out), 1);
        checkOutput("reset_vs", int'(bus.vsync_out), 1);
        checkOutput("reset_row", int'(bus.rom_row), 0);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
        checkOutput("lat_first", int'(bus.hsync_out), 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        checkOutput("lat_second", int'(bus.hsync_out), 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 9, 20);
            checkOutput("hold_hs", int'(bus.hsync_out), 0);
            checkOutput("hold_vs", int'(bus.vsync_out), 1);
            checkOutput("hold_rgb", int'(bus.rgb), 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, i < 8, 1'b1, 1'b1, 8 + i, 24);
            if (i == 0) checkOutput("glyph_row", int'(bus.rom_row), 8);
            if (i >= 1 && i <= 8) checkOutput("glyph_pix", int'(bus.rgb), (i <= 7) ? int'(FG) : int'(BG));
        end

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 40, 24);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        checkOutput("right_edge", int'(bus.rgb), 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8, 24);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        checkOutput("video_off", int'(bus.rgb), 0);

        bus.cursor_en = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8, 16);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        checkOutput("blink_phase0", int'(bus.rgb), int'(BG));
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
                applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
                applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
            end
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8, 16);
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
            checkOutput(k == 0 ? "blink_on" : "blink_off", int'(bus.rgb), k == 0 ? int'(FG) : int'(BG));
        end

        runFrames(6);

        bus.cursor_en = 1'b0;
        for (int x = 0; x < H_TOTAL; x++) begin
            reset = (x == X0 + 3);
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, x, 17);
            if (x == X0 + 3) begin
                checkOutput("rst_mid_rgb", int'(bus.rgb), 0);
                checkOutput("rst_mid_hs", int'(bus.hsync_out), 1);
                checkOutput("rst_mid_vs", int'(bus.vsync_out), 1);
                checkOutput("rst_mid_row", int'(bus.rom_row), 0);
            end
            if (x == X0 + 5) checkOutput("rst_first_pix", int'(bus.rgb), int'(BG));
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
